// File: rtl/audio_pkg.sv
// Shared definitions for the audio path: sequencer state encoding and the
// layout of a 40-bit note word (duration in ticks over half-period in clocks).
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } audio_state_t;

  localparam int NOTE_WORD_W          = 40;
  localparam int DUR_W                = 16;
  localparam int DUR_LSB              = 24;
  localparam int HP_W                 = 24;
  localparam int HP_LSB               = 0;
  localparam int DUTY_CYCLE_WIDTH_DEF = 8;

  function automatic logic [DUR_W-1:0] note_duration(input logic [NOTE_WORD_W-1:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

  function automatic logic [HP_W-1:0] note_half_period(input logic [NOTE_WORD_W-1:0] word);
    return word[HP_LSB +: HP_W];
  endfunction

endpackage

// File: rtl/game_over_note_rom.sv
// Note table ROM with a one-cycle registered read, built from a packed
// parameter image (word gi lives at bits [gi*40 +: 40]).
module game_over_note_rom
  import audio_pkg::*;
#(
  parameter int                               NUM_NOTES = 8,
  parameter int                               ADDR_W    = 3,
  parameter logic [NUM_NOTES*NOTE_WORD_W-1:0] NOTE_INIT = '0
) (
  input  logic                   clk,
  input  logic [ADDR_W-1:0]      addr,
  output logic [NOTE_WORD_W-1:0] q
);

  logic [NOTE_WORD_W-1:0] mem [NUM_NOTES];

  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_word
    assign mem[gi] = NOTE_INIT[gi*NOTE_WORD_W +: NOTE_WORD_W];
  end

  always_ff @(posedge clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/game_over_seq.sv
// Game-over jingle sequencer: walks the note table, generating an enveloped
// square wave as an 8-bit duty_cycle sample for the PWM stage.
module game_over_seq
  import audio_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int TICK_HZ          = 1000,
  parameter int NUM_NOTES        = 8,
  parameter logic [NUM_NOTES*NOTE_WORD_W-1:0] NOTE_INIT = {
    40'h0, 40'h0, 40'h0,
    {16'd600, 24'h02E978}, {16'd100, 24'h000000}, {16'd300, 24'h02E978},
    {16'd150, 24'h024FDB}, {16'd150, 24'h01F23F}},
  parameter int GAP_TICKS        = 20,
  parameter int AMPLITUDE        = 200,
  parameter int DECAY_TICKS      = 4,
  parameter int DUTY_CYCLE_WIDTH = DUTY_CYCLE_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        mute,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  output logic                        busy,
  output logic                        done
);

  // TICK_CYC must be at least 2 so the prefetched word is ready at note exit.
  localparam int TICK_CYC = CLK_FREQUENCY_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int IDX_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int SEG_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam int DECAY_W  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  localparam logic [TICK_W-1:0]           TICK_LAST  = TICK_W'(TICK_CYC - 1);
  localparam logic [SEG_W-1:0]            GAP_LAST   = SEG_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [DECAY_W-1:0]          DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);
  localparam logic [IDX_W-1:0]            IDX_LAST   = IDX_W'(NUM_NOTES - 1);
  localparam logic [DUTY_CYCLE_WIDTH-1:0] AMP        = DUTY_CYCLE_WIDTH'(AMPLITUDE);

  audio_state_t                state_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [TICK_W-1:0]           tick_cnt_reg;
  logic [SEG_W-1:0]            seg_cnt_reg;
  logic [HP_W-1:0]             tone_cnt_reg;
  logic                        phase_reg;
  logic [DUTY_CYCLE_WIDTH-1:0] env_reg;
  logic [DECAY_W-1:0]          decay_cnt_reg;
  logic [DUR_W-1:0]            dur_reg;
  logic [HP_W-1:0]             hp_reg;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle_reg;
  logic                        busy_reg;
  logic                        done_reg;

  logic [IDX_W-1:0]       rom_addr;
  logic [NOTE_WORD_W-1:0] rom_q;
  logic                   tick;
  logic                   note_end;
  logic                   gap_end;
  logic                   rom_is_end;
  logic [SEG_W-1:0]       dur_last;
  logic                   load_note;
  logic                   go_gap;
  logic                   go_done;
  logic [IDX_W-1:0]       load_idx;

  // While a note or gap runs the ROM already holds the following word.
  always_comb begin
    rom_addr = '0;
    if (!reset && (state_reg == ST_NOTE || state_reg == ST_GAP) && idx_reg != IDX_LAST)
      rom_addr = idx_reg + 1'b1;
  end

  game_over_note_rom #(
    .NUM_NOTES (NUM_NOTES),
    .ADDR_W    (IDX_W),
    .NOTE_INIT (NOTE_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .q    (rom_q)
  );

  assign tick       = (tick_cnt_reg == TICK_LAST);
  assign dur_last   = SEG_W'(dur_reg - 16'd1);
  assign note_end   = (state_reg == ST_NOTE) && tick && (seg_cnt_reg == dur_last);
  assign gap_end    = (state_reg == ST_GAP) && tick && (seg_cnt_reg == GAP_LAST);
  assign rom_is_end = (note_duration(rom_q) == '0);

  always_comb begin
    load_note = 1'b0;
    go_gap    = 1'b0;
    go_done   = 1'b0;
    load_idx  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (rom_is_end) go_done = 1'b1;
          else            load_note = 1'b1;
        end
      end
      ST_NOTE: begin
        if (note_end) begin
          if (idx_reg == IDX_LAST || (GAP_TICKS == 0 && rom_is_end)) begin
            go_done = 1'b1;
          end else if (GAP_TICKS == 0) begin
            load_note = 1'b1;
            load_idx  = idx_reg + 1'b1;
          end else begin
            go_gap = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          if (rom_is_end) begin
            go_done = 1'b1;
          end else begin
            load_note = 1'b1;
            load_idx  = idx_reg + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      tick_cnt_reg   <= '0;
      seg_cnt_reg    <= '0;
      tone_cnt_reg   <= '0;
      phase_reg      <= 1'b0;
      env_reg        <= '0;
      decay_cnt_reg  <= '0;
      dur_reg        <= '0;
      hp_reg         <= '0;
      duty_cycle_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (state_reg == ST_NOTE || state_reg == ST_GAP) begin
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
        if (tick) seg_cnt_reg <= seg_cnt_reg + 1'b1;
      end

      if (state_reg == ST_NOTE) begin
        if (hp_reg != '0) begin
          if (tone_cnt_reg == hp_reg - 1'b1) begin
            tone_cnt_reg <= '0;
            phase_reg    <= ~phase_reg;
          end else begin
            tone_cnt_reg <= tone_cnt_reg + 1'b1;
          end
        end
        // Envelope saturates at zero rather than wrapping to full scale.
        if (tick) begin
          if (decay_cnt_reg == DECAY_LAST) begin
            decay_cnt_reg <= '0;
            if (env_reg != '0) env_reg <= env_reg - 1'b1;
          end else begin
            decay_cnt_reg <= decay_cnt_reg + 1'b1;
          end
        end
      end

      if (load_note) begin
        state_reg     <= ST_NOTE;
        idx_reg       <= load_idx;
        dur_reg       <= note_duration(rom_q);
        hp_reg        <= note_half_period(rom_q);
        tick_cnt_reg  <= '0;
        seg_cnt_reg   <= '0;
        tone_cnt_reg  <= '0;
        phase_reg     <= 1'b1;
        env_reg       <= AMP;
        decay_cnt_reg <= '0;
        busy_reg      <= 1'b1;
      end else if (go_gap) begin
        state_reg    <= ST_GAP;
        tick_cnt_reg <= '0;
        seg_cnt_reg  <= '0;
      end else if (go_done) begin
        state_reg <= ST_DONE;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b1;
      end else if (state_reg == ST_DONE) begin
        state_reg <= ST_IDLE;
      end

      duty_cycle_reg <= (state_reg == ST_NOTE && !mute && hp_reg != '0 && phase_reg)
                        ? env_reg : '0;
    end
  end

  assign duty_cycle = duty_cycle_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_game_over_seq.sv
// Directed bench for game_over_seq: three configurations (two-note jingle with gap,
// early terminator word, fast envelope without gap) checked cycle by cycle.
module tb_game_over_seq;
  import audio_pkg::*;

  localparam logic [2*NOTE_WORD_W-1:0] NOTES_A = {16'd2, 24'd5, 16'd3, 24'd4};
  localparam logic [4*NOTE_WORD_W-1:0] NOTES_B = {16'd5, 24'd2, 16'd5, 24'd2,
                                                  16'd0, 24'd3, 16'd3, 24'd4};
  localparam logic [2*NOTE_WORD_W-1:0] NOTES_C = {16'd0, 24'd0, 16'd6, 24'd100};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       mute = 1'b0;
  logic [7:0] duty_a, duty_b, duty_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  game_over_seq #(.CLK_FREQUENCY_HZ(1000), .TICK_HZ(100), .NUM_NOTES(2), .NOTE_INIT(NOTES_A),
    .GAP_TICKS(2), .AMPLITUDE(200), .DECAY_TICKS(100), .DUTY_CYCLE_WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mute(mute),
    .duty_cycle(duty_a), .busy(busy_a), .done(done_a));

  game_over_seq #(.CLK_FREQUENCY_HZ(1000), .TICK_HZ(100), .NUM_NOTES(4), .NOTE_INIT(NOTES_B),
    .GAP_TICKS(2), .AMPLITUDE(200), .DECAY_TICKS(100), .DUTY_CYCLE_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mute(1'b0),
    .duty_cycle(duty_b), .busy(busy_b), .done(done_b));

  game_over_seq #(.CLK_FREQUENCY_HZ(1000), .TICK_HZ(100), .NUM_NOTES(2), .NOTE_INIT(NOTES_C),
    .GAP_TICKS(0), .AMPLITUDE(3), .DECAY_TICKS(1), .DUTY_CYCLE_WIDTH(8)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .mute(1'b0),
    .duty_cycle(duty_c), .busy(busy_c), .done(done_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n counts cycles after the start pulse was sampled (n=1 is the first NOTE cycle).
  function automatic int exp_a(int n);
    if (n >= 2 && n <= 31) return (((n - 2) / 4) % 2 == 0) ? 200 : 0;
    if (n >= 52 && n <= 71) return (((n - 52) / 5) % 2 == 0) ? 200 : 0;
    return 0;
  endfunction

  function automatic int exp_b(int n);
    if (n >= 2 && n <= 31) return (((n - 2) / 4) % 2 == 0) ? 200 : 0;
    return 0;
  endfunction

  function automatic int exp_c(int n);
    int e;
    if (n < 2 || n > 61) return 0;
    e = 3 - (n - 2) / 10;
    return (e < 0) ? 0 : e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({duty_a, duty_b, duty_c} !== 24'd0) begin
        failures++;
        $display("FAIL reset_duty k=%0d got=%0h exp=0", k, {duty_a, duty_b, duty_c});
      end
      checks++;
      if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'd0) begin
        failures++;
        $display("FAIL reset_flags k=%0d got=%b exp=000000", k,
                 {busy_a, busy_b, busy_c, done_a, done_b, done_c});
      end
      step();
    end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_sequence_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_a !== 8'(exp_a(n))) begin
        failures++;
        $display("FAIL seq_a_duty n=%0d got=%0d exp=%0d", n, duty_a, exp_a(n));
      end
      checks++;
      if (busy_a !== (n <= 70) || done_a !== (n == 71)) begin
        failures++;
        $display("FAIL seq_a_flags n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 n, busy_a, done_a, (n <= 70), (n == 71));
      end
    end
    $display("test_sequence_a: two notes with gap, done expected at cycle 71");
  endtask

  task automatic test_terminator_b();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_b !== 8'(exp_b(n))) begin
        failures++;
        $display("FAIL term_b_duty n=%0d got=%0d exp=%0d", n, duty_b, exp_b(n));
      end
      checks++;
      if (busy_b !== (n <= 50) || done_b !== (n == 51)) begin
        failures++;
        $display("FAIL term_b_flags n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 n, busy_b, done_b, (n <= 50), (n == 51));
      end
    end
    $display("test_terminator_b: zero-duration word ends sequence after gap");
  endtask

  task automatic test_envelope_c();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int n = 1; n <= 65; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_c !== 8'(exp_c(n))) begin
        failures++;
        $display("FAIL env_c_duty n=%0d got=%0d exp=%0d", n, duty_c, exp_c(n));
      end
      checks++;
      if (busy_c !== (n <= 60) || done_c !== (n == 61)) begin
        failures++;
        $display("FAIL env_c_flags n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 n, busy_c, done_c, (n <= 60), (n == 61));
      end
    end
    $display("test_envelope_c: envelope 3,2,1,0 saturating, no gap");
  endtask

  task automatic test_mute_and_restart();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_a !== ((n <= 3) ? 8'(exp_a(n)) : 8'd0)) begin
        failures++;
        $display("FAIL mute_a_duty n=%0d got=%0d exp=%0d", n, duty_a,
                 (n <= 3) ? exp_a(n) : 0);
      end
      checks++;
      if (busy_a !== (n <= 70) || done_a !== (n == 71)) begin
        failures++;
        $display("FAIL mute_a_flags n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 n, busy_a, done_a, (n <= 70), (n == 71));
      end
      if (n == 3) mute = 1'b1;
      start_a = (n == 10 || n == 60 || n == 71);
    end
    start_a = 1'b0;
    mute = 1'b0;
    $display("test_mute_and_restart: muted output, starts while busy/done ignored");
  endtask

  task automatic test_reset_mid_note();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_a !== 8'(exp_a(n))) begin
        failures++;
        $display("FAIL rst_a_pre n=%0d got=%0d exp=%0d", n, duty_a, exp_a(n));
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (duty_a !== 8'd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL rst_a_abort got duty=%0d busy=%b exp duty=0 busy=0", duty_a, busy_a);
    end
    for (int k = 0; k < 80; k++) begin
      step();
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || duty_a !== 8'd0) begin
        failures++;
        $display("FAIL rst_a_quiet k=%0d got done=%b busy=%b duty=%0d exp 0/0/0",
                 k, done_a, busy_a, duty_a);
      end
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      if (n > 1) step();
      checks++;
      if (duty_a !== 8'(exp_a(n))) begin
        failures++;
        $display("FAIL rst_a_replay_duty n=%0d got=%0d exp=%0d", n, duty_a, exp_a(n));
      end
      checks++;
      if (busy_a !== (n <= 70) || done_a !== (n == 71)) begin
        failures++;
        $display("FAIL rst_a_replay_flags n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 n, busy_a, done_a, (n <= 70), (n == 71));
      end
    end
    $display("test_reset_mid_note: abort without done, replay from note 0");
  endtask

  initial begin
    test_reset();
    test_sequence_a();
    test_terminator_b();
    test_envelope_c();
    test_mute_and_restart();
    test_reset_mid_note();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
